mips_multicycle_controller: RTL and testbench

Control unit for the multicycle MIPS datapath. It consumes the datapath's `Instruction` (IR contents) and `ZeroFlag` outputs, and drives every datapath control input through a Moore-style state machine, one state per instruction step. It sits beside the datapath in the processor top level, and the two together form the complete multicycle CPU.

---
 rtl/mips_multicycle_controller_if.sv | 26 ++
 rtl/mips_multicycle_controller.sv | 171 +++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mips_multicycle_controller_if.sv
// rtl/mips_multicycle_controller_if.sv - controller <-> datapath signal bundle
interface mips_multicycle_controller_if;
    logic [31:0] Instruction;
    logic        ZeroFlag;
    logic        PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite;
    logic        RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUoperation;
    logic        InstrRetired;
    logic        IllegalOp;

    modport master (
        input  Instruction, ZeroFlag,
        output PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
        output RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA,
        output ALUSrcB, PCSrc, ALUoperation, InstrRetired, IllegalOp
    );

    modport slave (
        output Instruction, ZeroFlag,
        input  PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
        input  RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA,
        input  ALUSrcB, PCSrc, ALUoperation, InstrRetired, IllegalOp
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - Moore FSM driving the multicycle MIPS datapath
module mips_multicycle_controller (
    input  logic                          clk,
    input  logic                          rst,
    mips_multicycle_controller_if.master  bus
);
    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                           MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6, RTEXEC = 4'd7,
                           RTWB = 4'd8, IEXEC = 4'd9, IWB = 4'd10, BEQ = 4'd11,
                           JUMP = 4'd12, JAL = 4'd13, JR = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_BEQ = 6'b000100,
                           OP_J = 6'b000010, OP_JAL = 6'b000011;

    localparam logic [5:0] FN_JR = 6'b001000, FN_ADD = 6'b100000, FN_SUB = 6'b100010,
                           FN_AND = 6'b100100, FN_OR = 6'b100101, FN_SLT = 6'b101010;

    logic [3:0] state, next_state;
    logic [5:0] op, funct;
    logic       illegal_decode;
    logic       illegal_q;
    logic       unused_ok;

    assign op     = bus.Instruction[31:26];
    assign funct  = bus.Instruction[5:0];
    // ZeroFlag gates the PC load inside the datapath; the FSM never looks at it.
    assign unused_ok = &{1'b0, bus.ZeroFlag, bus.Instruction[25:6]};

    always_comb begin
        next_state     = FETCH;
        illegal_decode = 1'b0;
        case (state)
            IDLE:   next_state = FETCH;
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:     next_state = MEMADR;
                    OP_ADDI, OP_SLTI: next_state = IEXEC;
                    OP_BEQ:           next_state = BEQ;
                    OP_J:             next_state = JUMP;
                    OP_JAL:           next_state = JAL;
                    OP_RTYPE: begin
                        case (funct)
                            FN_JR:                                     next_state = JR;
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:     next_state = RTEXEC;
                            default:                                   illegal_decode = 1'b1;
                        endcase
                    end
                    default:          illegal_decode = 1'b1;
                endcase
            end
            MEMADR: next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            RTEXEC: next_state = RTWB;
            IEXEC:  next_state = IWB;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (illegal_decode)
                illegal_q <= 1'b1;
        end
    end

    assign bus.IllegalOp = illegal_q;

    always_comb begin
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.MemRead      = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.RegDst       = 1'b0;
        bus.WriteRegSel  = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.WriteDataSel = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = 2'b00;
        bus.PCSrc        = 2'b00;
        bus.ALUoperation = 3'b010;
        bus.InstrRetired = 1'b0;
        case (state)
            IDLE:   bus.ALUoperation = 3'b000;
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.PCWrite = 1'b1;
            end
            DECODE: bus.ALUSrcB = 2'b11;
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
            end
            MEMWB: begin
                bus.MemtoReg     = 1'b1;
                bus.RegWrite     = 1'b1;
                bus.InstrRetired = 1'b1;
            end
            MEMWR: begin
                bus.IorD         = 1'b1;
                bus.MemWrite     = 1'b1;
                bus.InstrRetired = 1'b1;
            end
            RTEXEC: begin
                bus.ALUSrcA = 1'b1;
                case (funct)
                    FN_SUB:  bus.ALUoperation = 3'b110;
                    FN_AND:  bus.ALUoperation = 3'b000;
                    FN_OR:   bus.ALUoperation = 3'b001;
                    FN_SLT:  bus.ALUoperation = 3'b111;
                    default: bus.ALUoperation = 3'b010;
                endcase
            end
            RTWB: begin
                bus.RegDst       = 1'b1;
                bus.RegWrite     = 1'b1;
                bus.InstrRetired = 1'b1;
            end
            IEXEC: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUSrcB      = 2'b10;
                bus.ALUoperation = (op == OP_SLTI) ? 3'b111 : 3'b010;
            end
            IWB: begin
                bus.RegWrite     = 1'b1;
                bus.InstrRetired = 1'b1;
            end
            BEQ: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUoperation = 3'b110;
                bus.PCWriteCond  = 1'b1;
                bus.PCSrc        = 2'b10;
                bus.InstrRetired = 1'b1;
            end
            JUMP: begin
                bus.PCSrc        = 2'b01;
                bus.PCWrite      = 1'b1;
                bus.InstrRetired = 1'b1;
            end
            JAL: begin
                // Link write of PC+4 to $31 lands on the same edge as the PC update.
                bus.PCSrc        = 2'b01;
                bus.PCWrite      = 1'b1;
                bus.WriteRegSel  = 1'b1;
                bus.WriteDataSel = 1'b1;
                bus.RegWrite     = 1'b1;
                bus.InstrRetired = 1'b1;
            end
            JR: begin
                bus.PCSrc        = 2'b11;
                bus.PCWrite      = 1'b1;
                bus.InstrRetired = 1'b1;
            end
            default: bus.ALUoperation = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - directed bench for mips_multicycle_controller
module tb_mips_multicycle_controller;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    mips_multicycle_controller_if bus();

    mips_multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemWrite,MemRead,IRWrite,RegDst,WriteRegSel,
    //  MemtoReg,WriteDataSel,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUoperation,InstrRetired}
    logic [19:0] ctrl;
    assign ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemWrite, bus.MemRead,
                   bus.IRWrite, bus.RegDst, bus.WriteRegSel, bus.MemtoReg, bus.WriteDataSel,
                   bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ALUoperation,
                   bus.InstrRetired};

    function automatic logic [19:0] cv(input logic pcw, pcwc, iord, mw, mr, irw,
                                       input logic rd, wrs, m2r, wds, rw, asa,
                                       input logic [1:0] asb, pcs,
                                       input logic [2:0] aop, input logic ret);
        return {pcw, pcwc, iord, mw, mr, irw, rd, wrs, m2r, wds, rw, asa, asb, pcs, aop, ret};
    endfunction

    logic [19:0] e_idle, e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
    logic [19:0] e_rt_add, e_rt_sub, e_rt_slt, e_rtwb, e_addi, e_slti, e_iwb;
    logic [19:0] e_beq, e_jump, e_jal, e_jr;
    logic [19:0] seq [0:4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a negedge while in FETCH; walks n states then expects FETCH again.
    task automatic run(input string tag, input logic [31:0] instr, input int n);
        bus.Instruction = instr;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s[%0d]", tag, k), {12'd0, ctrl}, {12'd0, seq[k]});
            @(negedge clk);
        end
        check($sformatf("%s_back_to_fetch", tag), {12'd0, ctrl}, {12'd0, e_fetch});
    endtask

    initial begin
        e_idle   = '0;
        e_fetch  = cv(1,0,0,0,1,1, 0,0,0,0,0,0, 2'b01,2'b00,3'b010,0);
        e_decode = cv(0,0,0,0,0,0, 0,0,0,0,0,0, 2'b11,2'b00,3'b010,0);
        e_memadr = cv(0,0,0,0,0,0, 0,0,0,0,0,1, 2'b10,2'b00,3'b010,0);
        e_memrd  = cv(0,0,1,0,1,0, 0,0,0,0,0,0, 2'b00,2'b00,3'b010,0);
        e_memwb  = cv(0,0,0,0,0,0, 0,0,1,0,1,0, 2'b00,2'b00,3'b010,1);
        e_memwr  = cv(0,0,1,1,0,0, 0,0,0,0,0,0, 2'b00,2'b00,3'b010,1);
        e_rt_add = cv(0,0,0,0,0,0, 0,0,0,0,0,1, 2'b00,2'b00,3'b010,0);
        e_rt_sub = cv(0,0,0,0,0,0, 0,0,0,0,0,1, 2'b00,2'b00,3'b110,0);
        e_rt_slt = cv(0,0,0,0,0,0, 0,0,0,0,0,1, 2'b00,2'b00,3'b111,0);
        e_rtwb   = cv(0,0,0,0,0,0, 1,0,0,0,1,0, 2'b00,2'b00,3'b010,1);
        e_addi   = cv(0,0,0,0,0,0, 0,0,0,0,0,1, 2'b10,2'b00,3'b010,0);
        e_slti   = cv(0,0,0,0,0,0, 0,0,0,0,0,1, 2'b10,2'b00,3'b111,0);
        e_iwb    = cv(0,0,0,0,0,0, 0,0,0,0,1,0, 2'b00,2'b00,3'b010,1);
        e_beq    = cv(0,1,0,0,0,0, 0,0,0,0,0,1, 2'b00,2'b10,3'b110,1);
        e_jump   = cv(1,0,0,0,0,0, 0,0,0,0,0,0, 2'b00,2'b01,3'b010,1);
        e_jal    = cv(1,0,0,0,0,0, 0,1,0,1,1,0, 2'b00,2'b01,3'b010,1);
        e_jr     = cv(1,0,0,0,0,0, 0,0,0,0,0,0, 2'b00,2'b11,3'b010,1);

        rst = 1'b0;
        bus.Instruction = 32'h0;
        bus.ZeroFlag = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_idle_ctrl", {12'd0, ctrl}, {12'd0, e_idle});
        check("reset_illegal", {31'd0, bus.IllegalOp}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        seq[0] = e_fetch; seq[1] = e_decode; seq[2] = e_memadr; seq[3] = e_memrd; seq[4] = e_memwb;
        run("lw", 32'h8C220004, 5);
        seq[2] = e_memadr; seq[3] = e_memwr;
        run("sw", 32'hAC220004, 4);
        seq[2] = e_rt_sub; seq[3] = e_rtwb;
        run("sub", 32'h00430822, 4);
        seq[2] = e_rt_add;
        run("add", 32'h00430820, 4);
        seq[2] = e_rt_slt;
        run("slt", 32'h0043082A, 4);
        seq[2] = e_addi; seq[3] = e_iwb;
        run("addi", 32'h20220005, 4);
        seq[2] = e_slti;
        run("slti", 32'h28220005, 4);
        seq[2] = e_beq;
        bus.ZeroFlag = 1'b1;
        run("beq_z1", 32'h10220003, 3);
        bus.ZeroFlag = 1'b0;
        run("beq_z0", 32'h10220003, 3);
        seq[2] = e_jump;
        run("j", 32'h08000010, 3);
        seq[2] = e_jal;
        run("jal", 32'h0C000010, 3);
        seq[2] = e_jr;
        run("jr", 32'h03E00008, 3);

        check("illegal_before", {31'd0, bus.IllegalOp}, 32'd0);
        run("illegal_op", 32'hFC000000, 2);
        check("illegal_set", {31'd0, bus.IllegalOp}, 32'd1);
        seq[2] = e_jr;
        run("jr_after_illegal", 32'h03E00008, 3);
        check("illegal_sticky", {31'd0, bus.IllegalOp}, 32'd1);
        run("illegal_funct", 32'h00430801, 2);
        check("illegal_funct_flag", {31'd0, bus.IllegalOp}, 32'd1);

        bus.Instruction = 32'h00430822;
        @(negedge clk);
        @(negedge clk);
        check("mid_rtexec", {12'd0, ctrl}, {12'd0, e_rt_sub});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_idle_ctrl", {12'd0, ctrl}, {12'd0, e_idle});
        check("midreset_illegal_clr", {31'd0, bus.IllegalOp}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("release_fetch", {12'd0, ctrl}, {12'd0, e_fetch});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
